// File: rtl/seq_lock.sv
// rtl/seq_lock.sv - two-key combination lock with code programming and failed-attempt lockout
module seq_lock #(
    parameter int                  CODE_LEN     = 5,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE = 5'b01011,
    parameter int                  MAX_FAIL     = 3,
    parameter int                  LOCK_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       b0,
    input  logic       b1,
    input  logic       prog,
    output logic       out,
    output logic       alarm,
    output logic [3:0] hex_display
);

    localparam int TW = $clog2(LOCK_CYCLES + 1);
    localparam logic [3:0]    CNT_LAST = 4'(CODE_LEN - 1);
    localparam logic [3:0]    FAIL_MAX = 4'(MAX_FAIL);
    localparam logic [TW-1:0] T_LAST   = TW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {ENTRY, OPEN, PROG, LOCKOUT} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [3:0]          fail_cnt;
    logic [CODE_LEN-1:0] hist;
    logic [CODE_LEN-1:0] code;
    logic [TW-1:0]       timer;

    logic                press;
    logic                last;
    logic [CODE_LEN-1:0] shifted;

    // A press is valid only when exactly one key is down; b1 is the bit value.
    assign press   = b0 ^ b1;
    assign last    = (cnt == CNT_LAST);
    assign shifted = {hist[CODE_LEN-2:0], b1};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ENTRY;
            cnt      <= '0;
            hist     <= '0;
            fail_cnt <= '0;
            timer    <= '0;
            code     <= DEFAULT_CODE;
        end else begin
            case (state)
                ENTRY: begin
                    if (press) begin
                        if (last) begin
                            cnt  <= '0;
                            hist <= '0;
                            if (shifted == code) begin
                                state    <= OPEN;
                                fail_cnt <= '0;
                            end else begin
                                fail_cnt <= fail_cnt + 4'd1;
                                if (fail_cnt + 4'd1 == FAIL_MAX) begin
                                    state <= LOCKOUT;
                                    timer <= '0;
                                end
                            end
                        end else begin
                            cnt  <= cnt + 4'd1;
                            hist <= shifted;
                        end
                    end
                end
                OPEN: begin
                    // prog outranks a coincident key press
                    if (prog) begin
                        state <= PROG;
                        cnt   <= '0;
                        hist  <= '0;
                    end else if (press && b0) begin
                        state <= ENTRY;
                        cnt   <= '0;
                        hist  <= '0;
                    end
                end
                PROG: begin
                    if (press) begin
                        if (last) begin
                            code  <= shifted;
                            cnt   <= '0;
                            hist  <= '0;
                            state <= ENTRY;
                        end else begin
                            cnt  <= cnt + 4'd1;
                            hist <= shifted;
                        end
                    end
                end
                LOCKOUT: begin
                    if (timer == T_LAST) begin
                        state    <= ENTRY;
                        timer    <= '0;
                        fail_cnt <= '0;
                        cnt      <= '0;
                        hist     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ENTRY;
            endcase
        end
    end

    always_comb begin
        out         = (state == OPEN);
        alarm       = (state == LOCKOUT);
        hex_display = 4'h0;
        case (state)
            ENTRY, PROG: hex_display = cnt;
            OPEN:        hex_display = 4'hF;
            LOCKOUT:     hex_display = 4'hE;
            default:     hex_display = 4'h0;
        endcase
    end

endmodule
